// File: rtl/reset_sequencer_if.sv
// Reset-sequencer control/status bundle: lock and soft-reset requests in,
// per-domain resets, ready and last reset cause out.
interface reset_sequencer_if #(
    parameter int N_DOMAINS = 2
) ();
    logic                 pll_locked;
    logic                 soft_rst;
    logic [N_DOMAINS-1:0] rst_out;
    logic                 ready;
    logic [1:0]           rst_cause;

    modport master (
        output pll_locked, soft_rst,
        input  rst_out, ready, rst_cause
    );

    modport slave (
        input  pll_locked, soft_rst,
        output rst_out, ready, rst_cause
    );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on / lock-loss reset sequencer: holds all domains in reset until the
// clock source is locked, stretches, then releases domains one by one.
module reset_sequencer #(
    parameter int N_DOMAINS      = 2,
    parameter int STRETCH_CYCLES = 128,
    parameter int STAGGER_CYCLES = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               clk_12m,
    input  logic               rst_in_n,
    reset_sequencer_if.slave   bus
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    localparam logic [1:0] CAUSE_EXT  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    state_e                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [N_DOMAINS-1:0]   rst_out_q, rst_out_d;
    logic                   ready_q,   ready_d;
    logic [1:0]             cause_q,   cause_d;

    logic [N_DOMAINS-1:0]   shifted;
    logic [CNT_W-1:0]       last;

    // NOTE: synchroniser flops take the async reset too, so a stale "locked"
    // can never leak through into the first cycles after reset release.
    always_ff @(posedge clk_12m or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // NOTE: every next-state signal gets its default first so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        cause_d   = cause_q;
        shifted   = rst_out_q << 1;
        last      = (state_q == ST_STRETCH) ? STRETCH_LAST : STAGGER_LAST;

        case (state_q)
            ST_HOLD: begin
                rst_out_d = '1;
                ready_d   = 1'b0;
                if (locked_s) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end
            end
            default: begin
                // Lock loss outranks a simultaneous soft reset request.
                if (!locked_s) begin
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    cause_d   = CAUSE_LOCK;
                end else if (bus.soft_rst) begin
                    state_d   = ST_STRETCH;
                    cnt_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    cause_d   = CAUSE_SOFT;
                end else if (state_q == ST_STRETCH || state_q == ST_RELEASE) begin
                    if (cnt_q == last) begin
                        // Shifting a zero in from the bottom releases domains in ascending order.
                        cnt_d     = '0;
                        rst_out_d = shifted;
                        if (shifted == '0) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_12m or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cause_q   <= CAUSE_EXT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            cause_q   <= cause_d;
        end
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.ready     = ready_q;
    assign bus.rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed timing steps plus randomized lock/soft/reset
// traffic compared against an elapsed-time model of the release schedule.
module tb_reset_sequencer;

    localparam int N0 = 2;
    localparam int ST = 128;
    localparam int SG = 16;
    localparam int SY = 2;

    logic clk;
    logic rst_in_n;

    int tests = 0;
    int fails = 0;

    reset_sequencer_if #(.N_DOMAINS(N0)) bus0 ();
    reset_sequencer_if #(.N_DOMAINS(1))  bus1 ();

    reset_sequencer #(
        .N_DOMAINS(N0), .STRETCH_CYCLES(ST), .STAGGER_CYCLES(SG), .SYNC_STAGES(SY)
    ) dut0 (
        .clk_12m(clk), .rst_in_n(rst_in_n), .bus(bus0)
    );

    reset_sequencer #(
        .N_DOMAINS(1), .STRETCH_CYCLES(1), .STAGGER_CYCLES(1), .SYNC_STAGES(2)
    ) dut1 (
        .clk_12m(clk), .rst_in_n(rst_in_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edges elapsed since the last stretch started.
    bit         m_hold;
    int         m_elapsed;
    logic [1:0] m_cause;
    bit         m_sync[$];

    task automatic model_reset();
        m_hold    = 1'b1;
        m_elapsed = 0;
        m_cause   = 2'b00;
        m_sync    = {};
        for (int i = 0; i < SY; i++) m_sync.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit ls;
        if (!rst_in_n) begin
            model_reset();
            return;
        end
        ls = m_sync[0];
        if (m_hold) begin
            if (ls) begin
                m_hold    = 1'b0;
                m_elapsed = 0;
            end
        end else if (!ls) begin
            m_hold  = 1'b1;
            m_cause = 2'b01;
        end else if (bus0.soft_rst) begin
            m_elapsed = 0;
            m_cause   = 2'b10;
        end else if (m_elapsed < 1000000) begin
            m_elapsed++;
        end
        void'(m_sync.pop_front());
        m_sync.push_back(bus0.pll_locked);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [N0-1:0] exp_rst;
        logic          exp_ready;
        for (int i = 0; i < N0; i++)
            exp_rst[i] = m_hold || (m_elapsed < ST + i * SG);
        exp_ready = !m_hold && (m_elapsed >= ST + (N0 - 1) * SG);
        chk({tag, "_rst"},   32'(bus0.rst_out),   32'(exp_rst));
        chk({tag, "_ready"}, 32'(bus0.ready),     32'(exp_ready));
        chk({tag, "_cause"}, 32'(bus0.rst_cause), 32'(m_cause));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic async_reset(input string tag);
        #2 rst_in_n = 1'b0;
        #1;
        model_reset();
        check_model(tag);
        chk({tag, "_rst_ones"}, 32'(bus0.rst_out),   32'h3);
        chk({tag, "_rdy_low"},  32'(bus0.ready),     32'h0);
        chk({tag, "_cause00"},  32'(bus0.rst_cause), 32'h0);
        tick({tag, "_hold"});
        tick({tag, "_hold"});
        rst_in_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int down;
        down = 0;
        rst_in_n          = 1'b1;
        bus0.pll_locked   = 1'b1;
        bus0.soft_rst     = 1'b0;
        bus1.pll_locked   = 1'b0;
        bus1.soft_rst     = 1'b0;

        // Power-on reset without clock edges.
        #2 rst_in_n = 1'b0;
        #1;
        model_reset();
        check_model("por");
        chk("por_rst1",   32'(bus1.rst_out), 32'h1);
        chk("por_ready1", 32'(bus1.ready),   32'h0);
        tick("por_hold");
        tick("por_hold");
        rst_in_n = 1'b1;

        // Startup with constant lock: fixed edge numbers.
        for (int e = 1; e <= 150; e++) begin
            tick("boot");
            if (e == 130) chk("e130_rst",   32'(bus0.rst_out),   32'h3);
            if (e == 131) chk("e131_rst",   32'(bus0.rst_out),   32'h2);
            if (e == 146) chk("e146_ready", 32'(bus0.ready),     32'h0);
            if (e == 147) chk("e147_rst",   32'(bus0.rst_out),   32'h0);
            if (e == 147) chk("e147_ready", 32'(bus0.ready),     32'h1);
            if (e == 147) chk("e147_cause", 32'(bus0.rst_cause), 32'h0);
        end

        // Soft reset from RUN.
        bus0.soft_rst = 1'b1;
        tick("soft");
        bus0.soft_rst = 1'b0;
        chk("soft_rst_ones", 32'(bus0.rst_out),   32'h3);
        chk("soft_cause",    32'(bus0.rst_cause), 32'h2);
        for (int k = 1; k <= 150; k++) begin
            tick("soft_seq");
            if (k == 127) chk("soft_k127_bit0", 32'(bus0.rst_out[0]), 32'h1);
            if (k == 128) chk("soft_k128_bit0", 32'(bus0.rst_out[0]), 32'h0);
            if (k == 143) chk("soft_k143_ready", 32'(bus0.ready), 32'h0);
            if (k == 144) chk("soft_k144_ready", 32'(bus0.ready), 32'h1);
        end

        // Lock loss coinciding with soft reset: lock loss wins.
        bus0.pll_locked = 1'b0;
        tick("lost1");
        tick("lost2");
        bus0.soft_rst = 1'b1;
        tick("lost_soft");
        bus0.soft_rst = 1'b0;
        chk("lost_rst",   32'(bus0.rst_out),   32'h3);
        chk("lost_ready", 32'(bus0.ready),     32'h0);
        chk("lost_cause", 32'(bus0.rst_cause), 32'h1);

        // Soft reset while held is ignored.
        bus0.soft_rst = 1'b1;
        tick("hold_soft");
        bus0.soft_rst = 1'b0;
        tick("hold_soft2");
        chk("hold_soft_cause", 32'(bus0.rst_cause), 32'h1);
        chk("hold_soft_rst",   32'(bus0.rst_out),   32'h3);

        // Relock: bit 0 falls 129 edges after locked_s rises.
        bus0.pll_locked = 1'b1;
        for (int k = 1; k <= 135; k++) begin
            tick("relock");
            if (k == 130) chk("relock_k130_bit0", 32'(bus0.rst_out[0]), 32'h1);
            if (k == 131) chk("relock_k131_bit0", 32'(bus0.rst_out[0]), 32'h0);
        end

        // External reset mid-RELEASE.
        async_reset("midrel");

        // Randomized lock glitches, soft pulses and external resets.
        for (int c = 0; c < 4000; c++) begin
            bus0.soft_rst = ($urandom_range(0, 399) == 0);
            if (down > 0) begin
                down--;
                bus0.pll_locked = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                down = $urandom_range(0, 8);
                bus0.pll_locked = 1'b0;
            end else begin
                bus0.pll_locked = 1'b1;
            end
            if ($urandom_range(0, 1499) == 0) async_reset("rnd_arst");
            tick("rnd");
        end
        bus0.soft_rst = 1'b0;

        // Minimal build: release and ready on the same edge, 2 edges after locked_s.
        bus1.pll_locked = 1'b1;
        tick("min1");
        tick("min2");
        tick("min3");
        chk("min_a2_rst",   32'(bus1.rst_out), 32'h1);
        chk("min_a2_ready", 32'(bus1.ready),   32'h0);
        tick("min4");
        chk("min_a3_rst",   32'(bus1.rst_out), 32'h0);
        chk("min_a3_ready", 32'(bus1.ready),   32'h1);
        chk("min_cause",    32'(bus1.rst_cause), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
